// File: rtl/hash_checker_pkg.sv
// Shared defaults, widths and FSM state type for the hash checker.
package hash_checker_pkg;

  localparam int unsigned HASH_W_DEFAULT = 128;
  localparam int unsigned DEPTH_DEFAULT  = 128;
  // Occupancy count width: must represent 0..DEPTH inclusive.
  localparam int unsigned IDX_W          = $clog2(DEPTH_DEFAULT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Table address width, kept at least one bit for a single-entry table.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hash_store.sv
// Register table of hashes: one write port, one indexed combinational
// read port, and (with HASH_CHECKER_DEBUG_PORT_EN) a flat debug view.
module hash_store
  import hash_checker_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned HASH_W = HASH_W_DEFAULT,
  parameter int unsigned ADDR_W = addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [HASH_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [HASH_W-1:0]        rd_data_c
`ifdef HASH_CHECKER_DEBUG_PORT_EN
  ,
  output logic [HASH_W*DEPTH-1:0]  flat
`endif
);

  // Entry i sits at bits [HASH_W*i +: HASH_W] when flattened.
  logic [DEPTH-1:0][HASH_W-1:0] mem;

  // Table write; reset clears every entry so unwritten slots read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Indexed read used by the compare loop.
  assign rd_data_c = mem[rd_addr];

`ifdef HASH_CHECKER_DEBUG_PORT_EN
  // Debug view is a straight wiring of the table registers.
  assign flat = mem;
`endif

endmodule

// File: rtl/hash_checker.sv
// Hash checker: stores hashes into a table on newrdy edges and searches
// the occupied part of the table on checkrdy edges, one entry per cycle.
// Optional macro HASH_CHECKER_DEBUG_PORT_EN exposes the table as 'hashes'.
module hash_checker
  import hash_checker_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned HASH_W = HASH_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     newrdy,
  input  logic                     checkrdy,
  input  logic [HASH_W-1:0]        hash,
  output logic                     resultrdy,
  output logic                     matchfound
`ifdef HASH_CHECKER_DEBUG_PORT_EN
  ,
  output logic [HASH_W*DEPTH-1:0]  hashes
`endif
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned ADDR_W = addr_w(DEPTH);

  state_t              state;
  state_t              state_d;
  logic                new_q;
  logic                chk_q;
  logic [HASH_W-1:0]   hash_q;
  logic [CNT_W-1:0]    count;
  logic [ADDR_W-1:0]   idx;
  logic [HASH_W-1:0]   rd_data_c;

  logic                new_edge_c;
  logic                chk_edge_c;
  logic                full_c;
  logic                hit_c;
  logic                last_c;
  logic                acc_store_c;
  logic                acc_check_c;
  logic                wr_en_c;
  logic                idx_inc_c;
  logic                fin_c;
  logic                hit_fin_c;

  // A request is a 0->1 transition between consecutive samples.
  assign new_edge_c = newrdy & ~new_q;
  assign chk_edge_c = checkrdy & ~chk_q;
  assign full_c     = (count == CNT_W'(DEPTH));
  assign hit_c      = (rd_data_c == hash_q);
  assign last_c     = (count == CNT_W'(idx) + CNT_W'(1));

  // Edge-detect history; cleared by reset so a held level re-triggers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_q <= 1'b0;
      chk_q <= 1'b0;
    end else begin
      new_q <= newrdy;
      chk_q <= checkrdy;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and control decode; store wins over a coincident check.
  always_comb begin
    state_d     = state;
    acc_store_c = 1'b0;
    acc_check_c = 1'b0;
    wr_en_c     = 1'b0;
    idx_inc_c   = 1'b0;
    fin_c       = 1'b0;
    hit_fin_c   = 1'b0;
    case (state)
      IDLE: begin
        if (new_edge_c) begin
          acc_store_c = 1'b1;
          state_d     = STORE;
        end else if (chk_edge_c) begin
          acc_check_c = 1'b1;
          state_d     = CHECK;
        end
      end
      STORE: begin
        wr_en_c = ~full_c;
        fin_c   = 1'b1;
        state_d = IDLE;
      end
      CHECK: begin
        if (count == '0) begin
          fin_c   = 1'b1;
          state_d = IDLE;
        end else if (hit_c) begin
          fin_c     = 1'b1;
          hit_fin_c = 1'b1;
          state_d   = IDLE;
        end else if (last_c) begin
          fin_c   = 1'b1;
          state_d = IDLE;
        end else begin
          idx_inc_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: request latch, occupancy, scan index and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hash_q     <= '0;
      count      <= '0;
      idx        <= '0;
      resultrdy  <= 1'b0;
      matchfound <= 1'b0;
    end else begin
      if (acc_store_c || acc_check_c) begin
        resultrdy <= 1'b0;
        hash_q    <= hash;
      end
      if (acc_check_c) begin
        matchfound <= 1'b0;
        idx        <= '0;
      end
      if (wr_en_c) begin
        count <= count + CNT_W'(1);
      end
      if (idx_inc_c) begin
        idx <= idx + ADDR_W'(1);
      end
      if (fin_c) begin
        resultrdy <= 1'b1;
      end
      if (hit_fin_c) begin
        matchfound <= 1'b1;
      end
    end
  end

  // Storage table; writes land at the current occupancy count.
  hash_store #(
    .DEPTH  (DEPTH),
    .HASH_W (HASH_W),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en_c),
    .wr_addr   (count[ADDR_W-1:0]),
    .wr_data   (hash_q),
    .rd_addr   (idx),
    .rd_data_c (rd_data_c)
`ifdef HASH_CHECKER_DEBUG_PORT_EN
    ,
    .flat      (hashes)
`endif
  );

endmodule

// File: tb/tb_hash_checker.sv
// Self-checking bench for hash_checker against a queue-based table model.
module tb_hash_checker;

  localparam int DEPTH = 128;

  logic         clk;
  logic         rst;
  logic         newrdy;
  logic         checkrdy;
  logic [127:0] hash;
  logic         resultrdy;
  logic         matchfound;
`ifdef HASH_CHECKER_DEBUG_PORT_EN
  logic [128*DEPTH-1:0] hashes;
`endif

  int tests = 0;
  int fails = 0;

  logic [127:0] model_tbl[$];
  bit           model_match;

  hash_checker dut (
    .clk        (clk),
    .rst        (rst),
    .newrdy     (newrdy),
    .checkrdy   (checkrdy),
    .hash       (hash),
    .resultrdy  (resultrdy),
    .matchfound (matchfound)
`ifdef HASH_CHECKER_DEBUG_PORT_EN
    ,
    .hashes     (hashes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] tbl_entry(input int i);
    return dut.u_store.mem[i];
  endfunction

  // Number of table entries disagreeing with the model (unwritten = 0).
  function automatic int tbl_diffs();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [127:0] e;
      e = (i < model_tbl.size()) ? model_tbl[i] : 128'h0;
      if (tbl_entry(i) !== e) n++;
    end
    return n;
  endfunction

  // Expected check result: first matching index decides latency.
  function automatic void model_check(input logic [127:0] h, output int lat, output bit m);
    lat = (model_tbl.size() == 0) ? 1 : model_tbl.size();
    m = 1'b0;
    for (int i = 0; i < model_tbl.size(); i++) begin
      if (model_tbl[i] == h) begin
        lat = i + 1;
        m = 1'b1;
        break;
      end
    end
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    newrdy = 1'b0;
    checkrdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_tbl.delete();
    model_match = 1'b0;
  endtask

  // Raise the request(s), hold for 'hold' samples, optionally re-pulse
  // checkrdy at iteration 'poke', and measure edges until resultrdy.
  task automatic run_op(input bit dn, input bit dc, input logic [127:0] h,
                        input int hold, input int poke,
                        output int lat, output bit cleared);
    @(negedge clk);
    hash = h;
    newrdy = dn;
    checkrdy = dc;
    lat = 0;
    @(posedge clk);
    @(negedge clk);
    cleared = (resultrdy === 1'b0);
    for (int j = 0; j < 400; j++) begin
      if (j + 1 >= hold) begin
        newrdy = 1'b0;
        checkrdy = 1'b0;
      end
      if (poke > 0 && j == poke) checkrdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (resultrdy === 1'b1) begin
        lat = j + 1;
        break;
      end
    end
    newrdy = 1'b0;
    checkrdy = 1'b0;
  endtask

  task automatic do_store(input logic [127:0] h);
    int lat;
    bit clr;
    run_op(1'b1, 1'b0, h, 1, 0, lat, clr);
    tests++;
    if (lat !== 1) begin
      $display("FAIL store_latency got=%0d exp=1", lat);
      fails++;
    end
    if (model_tbl.size() < DEPTH) model_tbl.push_back(h);
  endtask

  task automatic test_reset();
    int lat;
    bit clr;
    apply_reset();
    tests++;
    if (resultrdy !== 1'b0 || matchfound !== 1'b0) begin
      $display("FAIL reset_outputs got=%b%b exp=00", resultrdy, matchfound);
      fails++;
    end
    tests++;
    if (dut.count !== 8'd0 || tbl_diffs() != 0) begin
      $display("FAIL reset_table count=%0d diffs=%0d exp=0/0", dut.count, tbl_diffs());
      fails++;
    end
    run_op(1'b0, 1'b1, 128'h0, 1, 0, lat, clr);
    tests++;
    if (lat !== 1 || matchfound !== 1'b0 || !clr) begin
      $display("FAIL empty_check lat=%0d match=%b clr=%b exp=1/0/1", lat, matchfound, clr);
      fails++;
    end
  endtask

  task automatic test_store_held();
    int lat;
    bit clr;
    logic [127:0] h;
    h = 128'h31d6cfe0d16ae931b73c59d7e0c089c0;
    apply_reset();
    run_op(1'b1, 1'b0, h, 2, 0, lat, clr);
    model_tbl.push_back(h);
    repeat (3) @(negedge clk);
    tests++;
    if (lat !== 1 || !clr) begin
      $display("FAIL held_store_latency lat=%0d clr=%b exp=1/1", lat, clr);
      fails++;
    end
    tests++;
    if (dut.count !== 8'd1 || tbl_entry(0) !== h) begin
      $display("FAIL held_store_once count=%0d e0=%h exp=1/%h", dut.count, tbl_entry(0), h);
      fails++;
    end
`ifdef HASH_CHECKER_DEBUG_PORT_EN
    tests++;
    if (hashes[127:0] !== h) begin
      $display("FAIL debug_view got=%h exp=%h", hashes[127:0], h);
      fails++;
    end
`endif
  endtask

  task automatic test_abc();
    int lat;
    int el;
    bit em;
    bit clr;
    logic [127:0] c;
    apply_reset();
    c = rnd128() | 128'h2;
    do_store(rnd128() | 128'h4);
    do_store(rnd128() | 128'h8);
    do_store(c);
    model_check(c, el, em);
    run_op(1'b0, 1'b1, c, 1, 0, lat, clr);
    tests++;
    if (lat !== el || matchfound !== em || lat !== 3) begin
      $display("FAIL abc_hit lat=%0d match=%b exp=3/1", lat, matchfound);
      fails++;
    end
    run_op(1'b0, 1'b1, 128'h1, 1, 0, lat, clr);
    tests++;
    if (lat !== 3 || matchfound !== 1'b0 || !clr) begin
      $display("FAIL abc_miss lat=%0d match=%b clr=%b exp=3/0/1", lat, matchfound, clr);
      fails++;
    end
  endtask

  task automatic test_full();
    int lat;
    int el;
    bit em;
    bit clr;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) do_store((i == 5) ? 128'h0 : rnd128());
    do_store(rnd128());
    tests++;
    if (dut.count !== 8'd128 || tbl_diffs() != 0) begin
      $display("FAIL full_drop count=%0d diffs=%0d exp=128/0", dut.count, tbl_diffs());
      fails++;
    end
    model_check(model_tbl[127], el, em);
    run_op(1'b0, 1'b1, model_tbl[127], 1, 0, lat, clr);
    tests++;
    if (lat !== el || matchfound !== em) begin
      $display("FAIL full_last_hit lat=%0d match=%b exp=%0d/%b", lat, matchfound, el, em);
      fails++;
    end
    model_check(128'h0, el, em);
    run_op(1'b0, 1'b1, 128'h0, 1, 0, lat, clr);
    tests++;
    if (lat !== el || matchfound !== em || el !== 6) begin
      $display("FAIL zero_hit lat=%0d match=%b exp=%0d/%b", lat, matchfound, el, em);
      fails++;
    end
  endtask

  task automatic test_collision();
    int lat;
    bit clr;
    logic [127:0] h;
    apply_reset();
    h = rnd128();
    run_op(1'b1, 1'b1, h, 1, 0, lat, clr);
    model_tbl.push_back(h);
    repeat (3) @(negedge clk);
    tests++;
    if (lat !== 1 || dut.count !== 8'd1 || tbl_entry(0) !== h || matchfound !== 1'b0) begin
      $display("FAIL coincident lat=%0d count=%0d match=%b exp=1/1/0", lat, dut.count, matchfound);
      fails++;
    end
    do_store(rnd128());
    do_store(rnd128());
    do_store(rnd128());
    run_op(1'b0, 1'b1, 128'h1, 1, 1, lat, clr);
    repeat (4) @(negedge clk);
    tests++;
    if (lat !== 4 || resultrdy !== 1'b1 || matchfound !== 1'b0) begin
      $display("FAIL check_during_check lat=%0d rdy=%b match=%b exp=4/1/0", lat, resultrdy, matchfound);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit clr;
    apply_reset();
    for (int i = 0; i < 100; i++) do_store(rnd128() | 128'h10);
    @(negedge clk);
    hash = 128'h3;
    checkrdy = 1'b1;
    repeat (50) @(negedge clk);
    checkrdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_tbl.delete();
    model_match = 1'b0;
    tests++;
    if (resultrdy !== 1'b0 || matchfound !== 1'b0 || dut.count !== 8'd0) begin
      $display("FAIL mid_reset_outs rdy=%b match=%b count=%0d exp=0/0/0", resultrdy, matchfound, dut.count);
      fails++;
    end
    tests++;
    if (tbl_diffs() != 0) begin
      $display("FAIL mid_reset_table diffs=%0d exp=0", tbl_diffs());
      fails++;
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 1'b1, 128'h3, 1, 0, lat, clr);
    tests++;
    if (lat !== 1 || matchfound !== 1'b0) begin
      $display("FAIL post_reset_check lat=%0d match=%b exp=1/0", lat, matchfound);
      fails++;
    end
  endtask

  task automatic test_level_through_reset();
    logic [127:0] h;
    h = rnd128();
    @(negedge clk);
    rst = 1'b1;
    hash = h;
    newrdy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    newrdy = 1'b0;
    model_tbl.delete();
    model_tbl.push_back(h);
    model_match = 1'b0;
    tests++;
    if (dut.count !== 8'd1 || tbl_entry(0) !== h || resultrdy !== 1'b1) begin
      $display("FAIL level_through_reset count=%0d rdy=%b exp=1/1", dut.count, resultrdy);
      fails++;
    end
  endtask

  task automatic test_random();
    int lat;
    int el;
    bit em;
    bit clr;
    logic [127:0] h;
    apply_reset();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(1) == 0) begin
        h = ($urandom_range(7) == 0) ? 128'h0 : rnd128();
        run_op(1'b1, 1'b0, h, $urandom_range(1, 3), 0, lat, clr);
        if (model_tbl.size() < DEPTH) model_tbl.push_back(h);
        el = 1;
        em = model_match;
      end else begin
        if (model_tbl.size() > 0 && $urandom_range(1) == 0)
          h = model_tbl[$urandom_range(model_tbl.size() - 1)];
        else
          h = rnd128();
        model_check(h, el, em);
        run_op(1'b0, 1'b1, h, $urandom_range(1, 3), 0, lat, clr);
        model_match = em;
      end
      tests++;
      if (lat !== el || matchfound !== em || !clr || dut.count !== 8'(model_tbl.size())) begin
        $display("FAIL random_op%0d lat=%0d match=%b count=%0d exp=%0d/%b/%0d",
                 n, lat, matchfound, dut.count, el, em, model_tbl.size());
        fails++;
      end
    end
    tests++;
    if (tbl_diffs() != 0) begin
      $display("FAIL random_table diffs=%0d exp=0", tbl_diffs());
      fails++;
    end
  endtask

  initial begin
    rst = 1'b1;
    newrdy = 1'b0;
    checkrdy = 1'b0;
    hash = '0;
    model_match = 1'b0;
    test_reset();
    test_store_held();
    test_abc();
    test_full();
    test_collision();
    test_reset_mid();
    test_level_through_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
